// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Brief    : Shared constants and the leading-zero blanking helper for the
//            multiplexed 8-digit display scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam logic [7:0] ANODE_OFF  = 8'hFF;
    localparam int         MAX_DIGITS = 8;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    // Returns a per-digit blank flag for leading zeros. Walking from the most
    // significant scanned digit downward, a digit is blanked while every digit
    // from it up to DIGITS-1 is zero. Digit 0 is never blanked so that a value
    // of zero still shows a single '0'. Bits at and above DIGITS are left 0;
    // those anodes are forced off elsewhere.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [31:0] sh,
        input logic        blank_lz,
        input int          digits
    );
        logic                  run;
        logic                  bit_k;
        logic [3:0]            nib;
        logic [MAX_DIGITS-1:0] mask;
        run  = 1'b1;
        mask = '0;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            bit_k = 1'b0;
            if (k < digits) begin
                nib   = 4'(sh >> (4 * k));
                run   = run & (nib == 4'd0);
                bit_k = blank_lz & (k != 0) & run;
            end
            // Shifting in from the LSB side places the first (k = 7) result
            // at bit 7 after all iterations.
            mask = {mask[MAX_DIGITS-2:0], bit_k};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_tick.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick
// Brief    : Slot prescaler. Counts 0..DIV-1, flags the last cycle of each
//            slot and reports whether the next cycle lies in the dark guard
//            interval at the start of a slot.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick #(
    parameter int DIV   = 100000,
    parameter int GUARD = 16
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick,
    output logic o_guard_next
);

    localparam int            CW     = $clog2(DIV);
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    assign o_tick     = (r_cnt == c_last);
    assign w_cnt_next = o_tick ? '0 : r_cnt + CW'(1);

    // The guard flag looks at the next count so the parent can register it
    // alongside the rest of its next-state outputs.
    generate
        if (GUARD > 0) begin : g_guard
            assign o_guard_next = (w_cnt_next < CW'(GUARD));
        end else begin : g_no_guard
            assign o_guard_next = 1'b0;
        end
    endgenerate

    // Free-running slot counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module   : display_scan
// Brief    : Time-multiplexed scan driver for an 8-digit common-anode display.
//            Presents one BCD digit at a time to the segment decoder, drives
//            active-low anodes, blanks leading zeros and invalid digits and
//            keeps all anodes dark for a short guard at each slot start.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int GUARD  = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iDigits,
    input  logic        iLoad,
    input  logic        iBlankLZ,
    output logic [3:0]  oBcd,
    output logic [7:0]  oAn,
    output logic        oFrame
);

    localparam logic [2:0] c_last_idx  = 3'(DIGITS - 1);
    // Anodes not scanned by this instance stay permanently off.
    localparam logic [7:0] c_an_unused = 8'(ANODE_OFF << DIGITS);

    logic        w_tick;
    logic        w_guard_next;
    logic        w_wrap;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [31:0] r_sh;
    logic [31:0] w_sh_next;
    logic [7:0]  w_lz;
    logic [7:0]  w_invalid;
    logic [7:0]  w_blank;
    logic [3:0]  w_nib;
    logic        w_dark;
    logic [3:0]  r_bcd;
    logic [7:0]  r_an;
    logic        r_frame;

    scan_tick #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) u_tick (
        .clk          (iClk),
        .rst          (iRst),
        .o_tick       (w_tick),
        .o_guard_next (w_guard_next)
    );

    // Next-state slot index and shadow data; outputs are derived from these
    // so a load or slot change shows up on the very next output cycle.
    assign w_wrap    = w_tick && (r_idx == c_last_idx);
    assign w_sh_next = iLoad ? iDigits : r_sh;

    always_comb begin
        w_idx_next = r_idx;
        if (w_wrap) begin
            w_idx_next = 3'd0;
        end else if (w_tick) begin
            w_idx_next = r_idx + 3'd1;
        end
    end

    generate
        for (genvar k = 0; k < MAX_DIGITS; k++) begin : g_digit
            assign w_invalid[k] = (w_sh_next[4*k +: 4] > BCD_MAX);
        end
    endgenerate

    assign w_lz    = lz_mask(w_sh_next, iBlankLZ, DIGITS);
    assign w_blank = w_lz | w_invalid;
    assign w_nib   = w_sh_next[{w_idx_next, 2'b00} +: 4];
    assign w_dark  = w_blank[w_idx_next];

    // Scan position and shadow register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_idx <= 3'd0;
            r_sh  <= 32'd0;
        end else begin
            r_idx <= w_idx_next;
            r_sh  <= w_sh_next;
        end
    end

    // Registered decoder value, anode enables and frame pulse.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_bcd   <= 4'd0;
            r_an    <= ANODE_OFF;
            r_frame <= 1'b0;
        end else begin
            r_bcd   <= w_dark ? 4'd0 : w_nib;
            r_an    <= (w_guard_next || w_dark) ? ANODE_OFF
                                                : (~(8'd1 << w_idx_next) | c_an_unused);
            r_frame <= w_wrap;
        end
    end

    assign oBcd   = r_bcd;
    assign oAn    = r_an;
    assign oFrame = r_frame;

endmodule
`default_nettype wire

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan driver that sits directly upstream of the BCD-to-7-segment decoder on the board's 8-digit common-anode display. Holds eight BCD digits in a shadow register and presents one digit at a time on a 4-bit bus to the decoder. Drives the active-low anode enables, with leading-zero blanking, invalid-digit blanking and an anti-ghosting guard interval.

## Interface
- DIGITS, 8: digits scanned, 1..8; anodes at and above DIGITS are held off.
- DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); ≥ 2.
- GUARD, 16: cycles at the start of each slot with all anodes off; 0 ≤ GUARD < DIV.
- iClk  in  1  system clock, rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iDigits  in  32  eight BCD nibbles; nibble k = iDigits[4k+3:4k]; digit 0 is rightmost.
- iLoad  in  1  captures iDigits into the shadow register on a rising clock edge.
- iBlankLZ  in  1  leading-zero blanking enable.
- oBcd  out  4  current digit value, to the decoder's iData.
- oAn  out  8  active-low anode enables; oAn[k] low lights digit k.
- oFrame  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- **State**
  - prescaler cnt: 0..DIV-1.
  - slot index idx: 0..DIGITS-1.
  - shadow register sh: 32 bits.
- **Prescaler:** cnt increments every cycle. At cnt = DIV-1, cnt goes to 0 and idx advances. idx wraps DIGITS-1 → 0.
- **Load:** iLoad = 1 sets sh ← iDigits. Loads on back-to-back cycles are all accepted; the last one wins. There is no handshake and no busy state.
- **Blank condition for digit k:** the digit is blanked if either of the following holds.
  - Its nibble is > 9 (invalid BCD).
  - Leading zero: iBlankLZ = 1, k ≠ 0, and every nibble k..DIGITS-1 equals 0. Digit 0 is never blanked as a leading zero.
- **Output function**, evaluated on the next-state values:
  - oBcd = sh nibble idx, or 0 if that digit is blanked.
  - oAn = 8'hFF if cnt < GUARD or the digit is blanked; otherwise only bit idx is low.
  - oAn[7:DIGITS] is always 1.
- oFrame = 1 for exactly one cycle, aligned with the first output cycle of slot 0 after a wrap. It does not pulse out of reset.
- **Width rules:** cnt width is clog2(DIV); idx width is 3; no arithmetic overflow is possible.

## Timing
- All outputs are registered. Any change to sh, idx, cnt or iBlankLZ is visible on the outputs 1 cycle later.
- **Reset values:** cnt = 0, idx = 0, sh = 0, oBcd = 0, oAn = 8'hFF, oFrame = 0. Reset is asynchronous: outputs return to these values immediately, mid-slot or mid-frame. After release, the first slot is digit 0 starting with its guard interval.
- Each slot lasts DIV cycles. The anode is lit for DIV-GUARD of them; one frame is DIGITS×DIV cycles.
- With GUARD = 0, the anode switches directly from digit to digit with no dark cycle.
- **iLoad on the cycle cnt = DIV-1:** the new slot shows the new data.
- **iLoad mid-slot:** the current digit changes in place 1 cycle later; the slot is not restarted.
- **DIGITS = 1:** idx stays 0. oFrame pulses every DIV cycles.

## Structure
- **Shared package display_pkg:**
  - ANODE_OFF = 8'hFF.
  - MAX_DIGITS = 8.
  - BCD_MAX = 9.
  - Function lz_mask(sh, iBlankLZ, DIGITS) returning the 8-bit blank vector.
- **Sub-module scan_tick:** parameterised DIV/GUARD prescaler. Outputs a one-cycle slot-advance tick and a guard-active flag. display_scan instantiates one.

## Test plan
- **Reset and scan (DIV = 4, GUARD = 1, DIGITS = 8):**
  - Reset, then load 32'h8765_4321.
  - oAn follows FF, FE, FE, FE, FF, FD… with oBcd = 1, 2, 3… per slot.
  - oFrame pulses every 32 cycles.
- **Leading-zero blanking:**
  - Load 32'h0000_0450 with iBlankLZ = 1: digits 3..7 give oAn = FF and oBcd = 0; digits 0..2 show 0, 5, 4.
  - Same data with iBlankLZ = 0: all eight digits light.
- **Invalid BCD:** load 32'h0000_00A3. Digit 1 stays dark with oBcd = 0; digit 0 shows 3.
- **Load at boundary:**
  - Assert iLoad with 32'h9999_9999 on the cycle cnt = DIV-1 of slot 2.
  - Slot 3 shows 9. Slots 0..2 of this frame keep their old values.
- **Reset mid-operation:**
  - Pulse iRst asynchronously mid-slot 5.
  - Outputs are FF/0/0 before the next clock edge. The scan restarts at digit 0, and sh reads 0 (all digits show 0 or are blanked).
- **DIGITS = 3:** oAn[7:3] is never low. idx wraps 2 → 0, and oFrame pulses every 3×DIV cycles.
